scb_cmd_seq: RTL and testbench
==============================

Name: scb_cmd_seq

Overview:
- Command sequencer directly upstream of the slow-control-board SPI engine.
- Buffers SPI transactions (command word plus length code) written by the register/control logic in a small FIFO.
- Issues each transaction to the SPI engine using its dacset/finish handshake, and captures the 128-bit readback per transaction.
- Enforces a microsecond-based timeout and reports sticky error flags.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.
- AW, 2, FIFO address width, log2(DEPTH).
- TIMEOUT_US, 1000, maximum usec ticks allowed between dacset assertion and finish assertion.

Ports:
- clk  in  1  system clock, same domain as the SPI engine.
- rst  in  1  asynchronous active-high reset.
- usec_66m  in  1  one-clk pulse every microsecond.
- cmd_wr  in  1  push strobe, one clk per entry.
- cmd_wr_data  in  136  SPI command word, MSB shifted first.
- cmd_wr_len  in  8  length code, bytes = code+1; legal range 0..16.
- fifo_count  out  AW+1  number of entries held.
- fifo_full  out  1  fifo_count == DEPTH.
- busy  out  1  state != IDLE or fifo_count != 0.
- scb_en  in  1  SPI engine idle flag.
- scb_command_dac_finish  in  1  SPI engine finish flag.
- SCB_SPIREAD  in  128  SPI engine readback bus.
- command_dacset  out  1  request to SPI engine.
- SCB_SPICMD  out  136  command held to SPI engine.
- SCB_SPILENGTH  out  8  length code held to SPI engine.
- rd_data  out  128  readback of the last completed transaction.
- rd_valid  out  1  one-clk pulse when rd_data updates.
- done_cnt  out  16  completed transactions, wraps at 65535 to 0.
- err_clr  in  1  clears sticky errors; also releases the ERROR state.
- err_overflow  out  1  sticky: a push was dropped because the FIFO was full.
- err_badlen  out  1  sticky: a push was dropped because cmd_wr_len > 16.
- err_timeout  out  1  sticky: the SPI engine did not finish in time.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- Push rules:
  - cmd_wr with len > 16: entry dropped, err_badlen set.
  - cmd_wr with the FIFO full: entry dropped, err_overflow set.
  - A pop and a push in the same clk are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
- err_clr has priority over a same-cycle set of any sticky flag (the flag clears).
- State IDLE:
  - If fifo_count > 0 and scb_en == 1: pop the head entry into SCB_SPICMD/SCB_SPILENGTH and go to LOAD.
- State LOAD:
  - Hold for one clk so the data is stable before the request.
  - Then set command_dacset = 1, clear the timeout counter, go to WAIT_FIN.
- State WAIT_FIN:
  - command_dacset stays 1 and SCB_SPICMD/SCB_SPILENGTH stay stable.
  - The timeout counter increments on each usec_66m pulse.
  - On scb_command_dac_finish == 1:
    - capture SCB_SPIREAD into rd_data;
    - pulse rd_valid for one clk;
    - increment done_cnt;
    - command_dacset = 0;
    - go to WAIT_REL.
  - If the counter reaches TIMEOUT_US first: command_dacset = 0, set err_timeout, go to ERROR.
  - If finish and timeout occur in the same clk, finish wins.
- State WAIT_REL:
  - Wait for scb_command_dac_finish == 0 and then scb_en == 1 (the engine back to idle).
  - Then go to IDLE.
  - Minimum spacing between successive dacset rising edges: 3 clk after finish.
- State ERROR:
  - command_dacset = 0; the FIFO is retained and no pops occur.
  - err_clr returns to IDLE; the queued entries then resume.
- Latency: push into an empty FIFO with scb_en = 1 gives command_dacset high 3 clk later (pop, LOAD, assert).
- Throughput: one transaction per engine cycle; there is no pipelining of requests.

Test Plan:
- Single transaction:
  - Stimulus: push cmd = 0xA5 in bits [135:128], len = 0; engine model finishes 40 clk after dacset, with readback 0x5A in [127:120].
  - Required: dacset rises at clk +3; rd_data[127:120] = 0x5A; rd_valid pulses once; done_cnt = 1.
- Back-to-back:
  - Stimulus: push 4 entries with len 0..3 in consecutive clks.
  - Required: fifo_full = 1 after the 4th push; four dacset pulses occur in push order, with SCB_SPILENGTH = 0, 1, 2, 3; done_cnt = 4; busy falls after the last WAIT_REL.
- Bad inputs:
  - Stimulus: a 5th push while full, and a push with len = 17.
  - Required: err_overflow = 1, err_badlen = 1, fifo_count unchanged; err_clr clears both flags on the next clk.
- Timeout:
  - Stimulus: engine never asserts finish; TIMEOUT_US = 5; usec_66m pulse every 66 clk.
  - Required: dacset drops after the 5th pulse; err_timeout = 1; remaining entries are held; err_clr resumes the next entry.
- Reset mid-transaction:
  - Stimulus: assert rst during WAIT_FIN.
  - Required: dacset = 0 immediately (asynchronous); FIFO empty; all sticky flags 0; done_cnt = 0.
- Wrap checks:
  - Stimulus: preload done_cnt to 65535 and complete one transaction; separately run 2×DEPTH transactions.
  - Required: done_cnt reads 0 after the rollover; FIFO pointer wrap preserves command order across the 2×DEPTH run.

Source files
------------

// File: rtl/scb_cmd_seq.sv
// scb_cmd_seq: buffers SPI transactions in a FIFO and sequences them into the SCB SPI engine
// using the dacset/finish handshake, with a usec timeout and sticky error flags.
module scb_cmd_seq #(
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int TIMEOUT_US = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          usec_66m,
  input  logic          cmd_wr,
  input  logic [135:0]  cmd_wr_data,
  input  logic [7:0]    cmd_wr_len,
  output logic [AW:0]   fifo_count,
  output logic          fifo_full,
  output logic          busy,
  input  logic          scb_en,
  input  logic          scb_command_dac_finish,
  input  logic [127:0]  SCB_SPIREAD,
  output logic          command_dacset,
  output logic [135:0]  SCB_SPICMD,
  output logic [7:0]    SCB_SPILENGTH,
  output logic [127:0]  rd_data,
  output logic          rd_valid,
  output logic [15:0]   done_cnt,
  input  logic          err_clr,
  output logic          err_overflow,
  output logic          err_badlen,
  output logic          err_timeout
);
  localparam int TW = $clog2(TIMEOUT_US + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_FIN, WAIT_REL, ERROR} state_t;
  state_t state_q, state_d;
  logic [143:0] mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [135:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [127:0] rd_data_q, rd_data_d;
  logic [15:0] done_q, done_d;
  logic dacset_q, dacset_d, rd_valid_q, rd_valid_d;
  logic ovf_q, ovf_d, badlen_q, badlen_d, tmo_err_q, tmo_err_d;
  logic full, bad, push, pop, tmo_hit;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    bad = cmd_wr && cmd_wr_len > 8'd16;
    push = cmd_wr && !bad && !full;
    pop = state_q == IDLE && cnt_q != '0 && scb_en;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = state_q;
    cmd_d = cmd_q;
    len_d = len_q;
    dacset_d = dacset_q;
    tmo_d = tmo_q;
    tmo_hit = 1'b0;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    done_d = done_q;
    case (state_q)
      IDLE: if (pop) begin
        {cmd_d, len_d} = mem[rp_q];
        state_d = LOAD;
      end
      LOAD: begin
        dacset_d = 1'b1;
        tmo_d = '0;
        state_d = WAIT_FIN;
      end
      WAIT_FIN: begin
        tmo_d = tmo_q + TW'(usec_66m);
        if (scb_command_dac_finish) begin
          rd_data_d = SCB_SPIREAD;
          rd_valid_d = 1'b1;
          done_d = done_q + 16'd1;
          dacset_d = 1'b0;
          state_d = WAIT_REL;
        end else if (tmo_d >= TW'(TIMEOUT_US)) begin
          dacset_d = 1'b0;
          tmo_hit = 1'b1;
          state_d = ERROR;
        end
      end
      WAIT_REL: state_d = (!scb_command_dac_finish && scb_en) ? IDLE : WAIT_REL;
      ERROR: state_d = err_clr ? IDLE : ERROR;
      default: state_d = IDLE;
    endcase
    ovf_d = !err_clr && (ovf_q || (cmd_wr && !bad && full));
    badlen_d = !err_clr && (badlen_q || bad);
    tmo_err_d = !err_clr && (tmo_err_q || tmo_hit);
  end
  always_ff @(posedge clk) if (push) mem[wp_q] <= {cmd_wr_data, cmd_wr_len};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      cmd_q <= '0;
      len_q <= '0;
      rd_data_q <= '0;
      done_q <= '0;
      dacset_q <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      badlen_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      cmd_q <= cmd_d;
      len_q <= len_d;
      rd_data_q <= rd_data_d;
      done_q <= done_d;
      dacset_q <= dacset_d;
      rd_valid_q <= rd_valid_d;
      ovf_q <= ovf_d;
      badlen_q <= badlen_d;
      tmo_err_q <= tmo_err_d;
    end
  end
  assign fifo_count = cnt_q;
  assign fifo_full = full;
  assign busy = state_q != IDLE || cnt_q != '0;
  assign command_dacset = dacset_q;
  assign SCB_SPICMD = cmd_q;
  assign SCB_SPILENGTH = len_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done_cnt = done_q;
  assign err_overflow = ovf_q;
  assign err_badlen = badlen_q;
  assign err_timeout = tmo_err_q;
endmodule

// File: tb/tb_scb_cmd_seq.sv
// tb_scb_cmd_seq: directed bench with a simple SPI engine model and a dacset order log.
module tb_scb_cmd_seq;
  logic clk = 0, rst = 1, usec = 0, cmd_wr = 0, scb_en = 1, fin = 0, err_clr = 0;
  logic [135:0] cmd_wr_data = '0;
  logic [7:0] cmd_wr_len = '0;
  logic [127:0] spiread = '0;
  logic [2:0] fifo_count;
  logic fifo_full, busy, dacset, rd_valid, err_ovf, err_badlen, err_timeout;
  logic [135:0] spicmd;
  logic [7:0] spilen;
  logic [127:0] rd_data;
  logic [15:0] done_cnt;
  int n_chk = 0, n_err = 0, rv_cnt = 0, ecnt = 0, p;
  logic hang = 0, dac_prev = 0;
  logic [7:0] tag_log[$], len_log[$];

  scb_cmd_seq #(.DEPTH(4), .AW(2), .TIMEOUT_US(5)) dut (
    .clk(clk), .rst(rst), .usec_66m(usec), .cmd_wr(cmd_wr), .cmd_wr_data(cmd_wr_data),
    .cmd_wr_len(cmd_wr_len), .fifo_count(fifo_count), .fifo_full(fifo_full), .busy(busy),
    .scb_en(scb_en), .scb_command_dac_finish(fin), .SCB_SPIREAD(spiread),
    .command_dacset(dacset), .SCB_SPICMD(spicmd), .SCB_SPILENGTH(spilen),
    .rd_data(rd_data), .rd_valid(rd_valid), .done_cnt(done_cnt), .err_clr(err_clr),
    .err_overflow(err_ovf), .err_badlen(err_badlen), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  initial forever begin
    repeat (65) @(negedge clk);
    usec = 1;
    @(negedge clk);
    usec = 0;
  end

  // Engine: finishes 40 clk after dacset, readback top byte is the inverted command byte.
  initial forever begin
    @(negedge clk);
    if (fin) fin = 0;
    else if (dacset && !hang) begin
      ecnt++;
      if (ecnt >= 40) begin
        fin = 1;
        spiread = {~spicmd[135:128], 112'h0, spilen};
        ecnt = 0;
      end
    end else ecnt = 0;
  end

  initial forever begin
    @(negedge clk);
    if (dacset && !dac_prev) begin
      tag_log.push_back(spicmd[135:128]);
      len_log.push_back(spilen);
    end
    dac_prev = dacset;
    if (rd_valid) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] tag, input logic [7:0] len);
    cmd_wr = 1;
    cmd_wr_data = {tag, 128'h0};
    cmd_wr_len = len;
    @(negedge clk);
    cmd_wr = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_dac();
    for (int i = 0; i < 500 && !dacset; i++) @(negedge clk);
    chk("dacset_timeout", dacset, 1);
  endtask

  task automatic pulse_clr();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", fifo_count, 0);
    chk("rst_dacset", dacset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_errs", {err_ovf, err_badlen, err_timeout, rd_valid}, 0);
    rst = 0;
    @(negedge clk);
    // single transaction and request latency
    push(8'hA5, 0);
    chk("lat_1", dacset, 0);
    @(negedge clk);
    chk("lat_2", dacset, 0);
    @(negedge clk);
    chk("lat_3", dacset, 1);
    wait_idle();
    chk("single_rd", rd_data[127:120], 8'h5A);
    chk("single_rv", rv_cnt, 1);
    chk("single_done", done_cnt, 1);
    // back-to-back with engine held busy so the FIFO fills
    tag_log.delete();
    len_log.delete();
    scb_en = 0;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 8'(i));
    chk("b2b_full", fifo_full, 1);
    chk("b2b_count", fifo_count, 4);
    push(8'hEE, 0);
    push(8'hEF, 17);
    chk("bad_ovf", err_ovf, 1);
    chk("bad_len", err_badlen, 1);
    chk("bad_count", fifo_count, 4);
    pulse_clr();
    chk("clr_flags", {err_ovf, err_badlen}, 0);
    scb_en = 1;
    wait_idle();
    chk("b2b_n", tag_log.size(), 4);
    for (int i = 0; i < 4 && i < tag_log.size(); i++) begin
      chk("b2b_len", len_log[i], 8'(i));
      chk("b2b_tag", tag_log[i], 8'h10 + 8'(i));
    end
    chk("b2b_done", done_cnt, 5);
    chk("b2b_rv", rv_cnt, 5);
    // timeout
    tag_log.delete();
    hang = 1;
    push(8'h11, 0);
    push(8'h22, 1);
    wait_dac();
    p = 0;
    for (int i = 0; i < 1000; i++) begin
      if (usec) p++;
      if (p == 5) break;
      @(negedge clk);
    end
    chk("tmo_pulses", p, 5);
    chk("tmo_pre", dacset, 1);
    @(negedge clk);
    chk("tmo_drop", dacset, 0);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_held", fifo_count, 1);
    repeat (3) @(negedge clk);
    chk("tmo_nopop", {dacset, fifo_count}, 4'b0001);
    hang = 0;
    pulse_clr();
    chk("tmo_clr", err_timeout, 0);
    wait_idle();
    chk("tmo_resume_n", tag_log.size(), 2);
    if (tag_log.size() == 2) chk("tmo_resume_tag", tag_log[1], 8'h22);
    chk("tmo_done", done_cnt, 6);
    // asynchronous reset during WAIT_FIN
    hang = 1;
    push(8'h33, 17);
    push(8'h44, 0);
    push(8'h55, 0);
    wait_dac();
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_dacset", dacset, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_errs", {err_ovf, err_badlen, err_timeout}, 0);
    chk("arst_done", done_cnt, 0);
    @(negedge clk);
    rst = 0;
    hang = 0;
    @(negedge clk);
    // done_cnt rollover
    force dut.done_q = 16'hFFFF;
    @(negedge clk);
    release dut.done_q;
    chk("wrap_pre", done_cnt, 16'hFFFF);
    push(8'h66, 0);
    wait_idle();
    chk("wrap_done", done_cnt, 0);
    // 2xDEPTH run through pointer wrap
    tag_log.delete();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 500 && fifo_full; k++) @(negedge clk);
      push(8'h80 + 8'(i), 8'(i % 4));
    end
    wait_idle();
    chk("order_n", tag_log.size(), 8);
    for (int i = 0; i < 8 && i < tag_log.size(); i++) chk("order_tag", tag_log[i], 8'h80 + 8'(i));
    chk("order_done", done_cnt, 8);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
